line_buffer_scheduler: RTL

Sequences the two ping-pong sprite line buffers that sit between the sprite controller and VGA scan-out. At each scanline start it swaps the display and back buffers. It then clears the back buffer to transparent, one pixel per cycle, and afterwards admits slice-write requests from the sprite controller one at a time through the line_load/line_busy handshake. It also reports per-line slice counts and a sticky underrun flag for lines whose clear or fill did not finish in time.

---
 rtl/gpu_pkg.sv | 13 +
 rtl/line_buffer_scheduler.sv | 105 ++++++++++
 2 files changed

// File: rtl/gpu_pkg.sv
// Definitions shared by the sprite line-buffer path: scheduler state encoding
// and the default line length, so the slice writer and VGA side agree.
package gpu_pkg;

  localparam int LINE_WIDTH = 640;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FILL  = 2'd1,
    WAIT  = 2'd2
  } line_state_e;

endpackage

// File: rtl/line_buffer_scheduler.sv
// Ping-pong sprite line buffer sequencer: swaps buffers at each scanline,
// clears the back buffer, then grants slice writes one at a time.
module line_buffer_scheduler
  import gpu_pkg::*;
#(
  parameter int WIDTH = LINE_WIDTH,
  parameter int ADDR  = 10,
  parameter int CNT   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scanline_start,
  input  logic            line_load,
  output logic            line_busy,
  output logic            disp_sel,
  output logic            clr_we,
  output logic [ADDR-1:0] clr_addr,
  output logic            slice_start,
  input  logic            slice_done,
  output logic            slice_abort,
  output logic [CNT-1:0]  slices_last,
  output logic            underrun,
  input  logic            underrun_clr
);

  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(WIDTH - 1);
  localparam logic [CNT-1:0]  CNT_MAX   = '1;

  line_state_e    state;
  line_state_e    state_next;
  logic [CNT-1:0] slice_cnt;
  logic [CNT-1:0] cnt_now;
  logic           clear_last;
  logic           done_ok;
  logic           grant;
  logic           abort_evt;
  logic           underrun_evt;

  assign clear_last   = (state == CLEAR) && (clr_addr == LAST_ADDR);
  assign done_ok      = (state == WAIT) && slice_done;
  // A slice finishing in the swap cycle still counts toward the old line.
  assign cnt_now      = (done_ok && slice_cnt != CNT_MAX) ? slice_cnt + CNT'(1) : slice_cnt;
  assign grant        = (state == FILL) && line_load && !scanline_start;
  assign abort_evt    = scanline_start && (state == WAIT) && !slice_done;
  assign underrun_evt = scanline_start && ((state == CLEAR) || abort_evt);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // NOTE: default assignment first so no path through the block leaves
  // state_next unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    if (scanline_start) begin
      state_next = CLEAR;
    end else begin
      case (state)
        CLEAR:   if (clear_last) state_next = FILL;
        FILL:    if (line_load)  state_next = WAIT;
        WAIT:    if (slice_done) state_next = FILL;
        default: state_next = CLEAR;
      endcase
    end
  end

  always_comb begin
    line_busy = (state != FILL);
    clr_we    = (state == CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_addr    <= '0;
      disp_sel    <= 1'b0;
      slice_cnt   <= '0;
      slices_last <= '0;
      underrun    <= 1'b0;
      slice_start <= 1'b0;
      slice_abort <= 1'b0;
    end else begin
      slice_start <= grant;
      slice_abort <= abort_evt;

      if (scanline_start || clear_last || state != CLEAR) clr_addr <= '0;
      else                                                clr_addr <= clr_addr + ADDR'(1);

      if (scanline_start) begin
        disp_sel    <= ~disp_sel;
        slices_last <= cnt_now;
        slice_cnt   <= '0;
      end else begin
        slice_cnt   <= cnt_now;
      end

      // A new underrun event outranks a coincident clear request.
      if (underrun_evt)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

endmodule
